// File: rtl/lhca_pkg.sv
// rtl/lhca_pkg.sv - shared types, defaults and helpers for the LHCA generator blocks
//
// Contents:
//   lhca_state_e       sequencer states
//   LHCA_*_DEFAULT     reset rule vector and reset seed
//   lhca_seed_fix()    substitutes a nonzero seed for an all-zero one
package lhca_pkg;

    localparam int         LHCA_WIDTH        = 8;
    localparam logic [7:0] LHCA_RULE_DEFAULT = 8'h06;
    localparam logic [7:0] LHCA_SEED_DEFAULT = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        STEP,
        EMIT,
        DONE
    } lhca_state_e;

    // The all-zero state is a fixed point of every rule 90/150 mix, so a
    // zero seed would produce a dead generator.
    function automatic logic [LHCA_WIDTH-1:0] lhca_seed_fix(input logic [LHCA_WIDTH-1:0] seed);
        return (seed == '0) ? LHCA_SEED_DEFAULT : seed;
    endfunction

endpackage

// File: rtl/lhca_step.sv
// rtl/lhca_step.sv - combinational next-state function of a null-boundary hybrid 90/150 CA
//
// Ports:
//   state       in   WIDTH  current cell values
//   rule        in   WIDTH  per-cell rule: 1 = rule 150, 0 = rule 90
//   next_state  out  WIDTH  cell values after one step
module lhca_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] rule,
    output logic [WIDTH-1:0] next_state
);

    // Zero pad on both ends: padded[i] is cell i-1, padded[i+2] is cell i+1.
    logic [WIDTH+1:0] padded;

    assign padded = {1'b0, state, 1'b0};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign next_state[i] = padded[i] ^ padded[i+2] ^ (rule[i] & state[i]);
    end

endmodule

// File: rtl/lhca_stream_ctrl.sv
// rtl/lhca_stream_ctrl.sv - run sequencer that streams LHCA words over valid/ready
//
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   cfg_we/rule/seed      configuration write, accepted only in IDLE
//   start/count           begin a run of count words, accepted only in IDLE
//   abort                 return to IDLE from any active state
//   out_data/valid/ready  word stream, one word every STRIDE CA steps
//   busy                  high outside IDLE
//   done                  one-cycle pulse on normal completion
//   lockup                sticky: the CA hit the all-zero state
//   state_q               raw CA state
module lhca_stream_ctrl
    import lhca_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RULE_INIT = LHCA_RULE_DEFAULT,
    parameter logic [WIDTH-1:0] SEED_INIT = LHCA_SEED_DEFAULT,
    parameter int               STRIDE    = 1,
    parameter int               CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_rule,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             lockup,
    output logic [WIDTH-1:0] state_q
);

    localparam logic [7:0] STRIDE_M1 = 8'(STRIDE - 1);

    lhca_state_e      fsm_q, fsm_d;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] rule_q, rule_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic             lockup_q, lockup_d;
    logic             zero_done_q, zero_done_d;
    logic [WIDTH-1:0] step_next;

    lhca_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .state     (state_q),
        .rule      (rule_q),
        .next_state(step_next)
    );

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rule_d      = rule_q;
        seed_d      = seed_q;
        remaining_d = remaining_q;
        step_cnt_d  = step_cnt_q;
        lockup_d    = lockup_q;
        zero_done_d = 1'b0;

        // Abort wins over everything, including a same-cycle handshake.
        if (abort && fsm_q != IDLE) begin
            fsm_d = IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    // The config write lands on the same edge as start, so
                    // SEED already sees the new seed and rule.
                    if (cfg_we) begin
                        rule_d = cfg_rule;
                        seed_d = lhca_seed_fix(cfg_seed);
                    end
                    if (start) begin
                        if (count != '0) begin
                            remaining_d = count;
                            lockup_d    = 1'b0;
                            fsm_d       = SEED;
                        end else begin
                            zero_done_d = 1'b1;
                        end
                    end
                end
                SEED: begin
                    state_d    = seed_q;
                    step_cnt_d = STRIDE_M1;
                    fsm_d      = STEP;
                end
                STEP: begin
                    if (step_next == '0) begin
                        state_d  = seed_q;
                        lockup_d = 1'b1;
                    end else begin
                        state_d = step_next;
                    end
                    if (step_cnt_q == 8'd0) begin
                        fsm_d = EMIT;
                    end else begin
                        step_cnt_d = step_cnt_q - 8'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        remaining_d = remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            fsm_d = DONE;
                        end else begin
                            fsm_d      = STEP;
                            step_cnt_d = STRIDE_M1;
                        end
                    end
                end
                DONE: begin
                    fsm_d = IDLE;
                end
                default: begin
                    fsm_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fsm_q       <= IDLE;
            state_q     <= SEED_INIT;
            rule_q      <= RULE_INIT;
            seed_q      <= SEED_INIT;
            remaining_q <= '0;
            step_cnt_q  <= 8'd0;
            lockup_q    <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rule_q      <= rule_d;
            seed_q      <= seed_d;
            remaining_q <= remaining_d;
            step_cnt_q  <= step_cnt_d;
            lockup_q    <= lockup_d;
            zero_done_q <= zero_done_d;
        end
    end

    // Decoded straight from the state register so reset clears them at once.
    assign out_valid = (fsm_q == EMIT);
    assign out_data  = state_q;
    assign busy      = (fsm_q != IDLE);
    assign done      = (fsm_q == DONE) | zero_done_q;
    assign lockup    = lockup_q;

endmodule

// File: tb/tb_lhca_stream_ctrl.sv
// tb/tb_lhca_stream_ctrl.sv - self-checking bench for lhca_stream_ctrl
module tb_lhca_stream_ctrl;

    localparam int STRIDE = 1;

    logic        CLK;
    logic        RESET;
    logic        cfg_we;
    logic [7:0]  cfg_rule;
    logic [7:0]  cfg_seed;
    logic        start;
    logic [15:0] count;
    logic        abort;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        lockup;
    logic [7:0]  state_q;

    int checks = 0;
    int errors = 0;

    // Model view of the stored configuration and the expected word stream
    // ({lockup flag, word} per emitted word).
    logic [7:0] m_rule = 8'h06;
    logic [7:0] m_seed = 8'h01;
    logic [8:0] exp_q[$];

    lhca_stream_ctrl #(
        .STRIDE(STRIDE)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .cfg_we   (cfg_we),
        .cfg_rule (cfg_rule),
        .cfg_seed (cfg_seed),
        .start    (start),
        .count    (count),
        .abort    (abort),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .lockup   (lockup),
        .state_q  (state_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Word-level CA step: (s << 1) puts the lower neighbour into each cell,
    // (s >> 1) the upper one; cells shifted in from outside are zero.
    function automatic logic [7:0] ref_next(input logic [7:0] s, input logic [7:0] r);
        return (s << 1) ^ (s >> 1) ^ (r & s);
    endfunction

    function automatic logic [7:0] ref_seed(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic build_expected(input logic [15:0] n);
        logic [7:0] s;
        logic [7:0] nx;
        logic       lk;
        exp_q.delete();
        s  = m_seed;
        lk = 1'b0;
        for (int w = 0; w < int'(n); w++) begin
            for (int k = 0; k < STRIDE; k++) begin
                nx = ref_next(s, m_rule);
                if (nx == 8'h00) begin
                    nx = m_seed;
                    lk = 1'b1;
                end
                s = nx;
            end
            exp_q.push_back({lk, s});
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low for 5 cycles at the first word
    task automatic run(input logic do_cfg, input logic [7:0] r, input logic [7:0] sd,
                       input logic [15:0] n, input int mode);
        int         got, cyc, stall, dones;
        logic       first_seen, held_v;
        logic [7:0] held;
        got = 0; cyc = 0; stall = 0; dones = 0;
        first_seen = 1'b0; held_v = 1'b0; held = 8'h00;
        if (do_cfg) begin
            m_rule = r;
            m_seed = ref_seed(sd);
        end
        @(negedge CLK);
        cfg_we = do_cfg; cfg_rule = r; cfg_seed = sd; start = 1'b1; count = n;
        @(negedge CLK);
        cfg_we = 1'b0; start = 1'b0;
        check("start_busy", busy, 1);
        check("start_lockup_clear", lockup, 0);
        while (got < int'(n) && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = (stall >= 5);
            endcase
            if (cyc == 1) check("seed_load", state_q, m_seed);
            if (done) dones++;
            if (out_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    check("first_latency", cyc, STRIDE + 1);
                end
                if (held_v) check("hold_data", out_data, held);
                if (out_ready) begin
                    check("word", out_data, exp_q[got][7:0]);
                    check("word_lockup", lockup, exp_q[got][8]);
                    got++;
                    held_v = 1'b0;
                end else begin
                    held   = out_data;
                    held_v = 1'b1;
                    stall++;
                end
            end
            @(negedge CLK);
            cyc++;
        end
        out_ready = 1'b0;
        check("words_accepted", got, n);
        check("no_early_done", dones, 0);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        @(negedge CLK);
        check("done_clear", done, 0);
        check("busy_fall", busy, 0);
    endtask

    typedef struct {
        logic       do_cfg;
        logic [7:0] rule;
        logic [7:0] seed;
        int         mode;
        logic [7:0] w0, w1, w2;
        logic       lk;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc, got;

        vecs[0] = '{1'b1, 8'h06, 8'h01, 0, 8'h02, 8'h07, 8'h0B, 1'b0};
        vecs[1] = '{1'b0, 8'h06, 8'h01, 2, 8'h02, 8'h07, 8'h0B, 1'b0};
        vecs[2] = '{1'b1, 8'hFF, 8'hDB, 0, 8'hDB, 8'hDB, 8'hDB, 1'b1};
        vecs[3] = '{1'b1, 8'h06, 8'h00, 1, 8'h02, 8'h07, 8'h0B, 1'b0};
        vecs[4] = '{1'b1, 8'h00, 8'h01, 0, 8'h02, 8'h05, 8'h08, 1'b0};

        RESET = 1'b1; cfg_we = 1'b0; cfg_rule = 8'h00; cfg_seed = 8'h00;
        start = 1'b0; count = 16'd0; abort = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lockup", lockup, 0);
        check("rst_state", state_q, 8'h01);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 5; i++) begin
            exp_q.delete();
            exp_q.push_back({vecs[i].lk, vecs[i].w0});
            exp_q.push_back({vecs[i].lk, vecs[i].w1});
            exp_q.push_back({vecs[i].lk, vecs[i].w2});
            run(vecs[i].do_cfg, vecs[i].rule, vecs[i].seed, 16'd3, vecs[i].mode);
        end

        // Abort during the second EMIT with ready high.
        @(negedge CLK);
        cfg_we = 1'b1; cfg_rule = 8'h06; cfg_seed = 8'h01; start = 1'b1; count = 16'd10;
        m_rule = 8'h06; m_seed = 8'h01;
        @(negedge CLK);
        cfg_we = 1'b0; start = 1'b0; out_ready = 1'b1;
        cyc = 0; got = 0;
        while (cyc < 50 && !(out_valid && got == 1)) begin
            if (out_valid) got++;
            @(negedge CLK);
            cyc++;
        end
        check("abort_reach_second", got, 1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0; out_ready = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_no_done", done, 0);
        check("abort_counted", dut.remaining_q, 16'd9);
        @(negedge CLK);
        check("abort_no_done_late", done, 0);

        // Zero-count start: done pulse only, busy stays low.
        start = 1'b1; count = 16'd0;
        @(negedge CLK);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge CLK);
        check("zero_done_clear", done, 0);
        check("zero_busy_late", busy, 0);

        // Config write and start during a run are ignored.
        start = 1'b1; count = 16'd2;
        @(negedge CLK);
        start = 1'b0;
        cfg_we = 1'b1; cfg_rule = 8'hAA; cfg_seed = 8'h77; start = 1'b1; count = 16'd5;
        @(negedge CLK);
        cfg_we = 1'b0; start = 1'b0;
        check("busy_cfg_rule", dut.rule_q, 8'h06);
        check("busy_cfg_seed", dut.seed_q, 8'h01);
        out_ready = 1'b1;
        cyc = 0;
        while (cyc < 50 && !done) begin
            @(negedge CLK);
            cyc++;
        end
        out_ready = 1'b0;
        check("busy_cfg_run_done", done, 1);
        @(negedge CLK);
        check("busy_cfg_idle", busy, 0);

        // Randomised runs against the model.
        for (int t = 0; t < 20; t++) begin
            logic       dc;
            logic [7:0] r, sd;
            logic [15:0] n;
            dc = ($urandom_range(0, 3) != 0);
            r  = 8'($urandom);
            sd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            n  = 16'($urandom_range(1, 5));
            if (dc) begin
                m_rule = r;
                m_seed = ref_seed(sd);
            end
            build_expected(n);
            run(dc, r, sd, n, 1);
        end

        // Asynchronous reset in STEP.
        @(negedge CLK);
        cfg_we = 1'b1; cfg_rule = 8'h00; cfg_seed = 8'h55; start = 1'b1; count = 16'd3;
        @(negedge CLK);
        cfg_we = 1'b0; start = 1'b0;
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check("areset_busy", busy, 0);
        check("areset_state", state_q, 8'h01);
        check("areset_rule", dut.rule_q, 8'h06);
        check("areset_seed", dut.seed_q, 8'h01);
        @(negedge CLK);
        RESET = 1'b0;

        // Asynchronous reset while a word is held under backpressure.
        start = 1'b1; count = 16'd2;
        @(negedge CLK);
        start = 1'b0;
        cyc = 0;
        while (cyc < 20 && !out_valid) begin
            @(negedge CLK);
            cyc++;
        end
        check("emit_reached", out_valid, 1);
        #2 RESET = 1'b1;
        #1;
        check("areset_valid", out_valid, 0);
        check("areset_lockup", lockup, 0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lhca_stream_ctrl.md
Name: lhca_stream_ctrl

Overview:
- Sequencer for the 8-cell linear hybrid cellular automaton (LHCA) pseudo-random generator.
- Owns the CA state register, a per-cell rule vector (rule 90 or rule 150) and the seed.
- Runs the CA for a requested number of output words, emitting one word every STRIDE steps over a valid/ready stream.
- Detects and recovers from the all-zero lockup state; sits between a host config/start interface and any downstream consumer of random words.

Parameters:
- WIDTH, 8: number of CA cells and output word width.
- RULE_INIT, 8'h06: reset rule vector. Bit i = 1 makes cell i rule 150 (self ^ left ^ right); 0 makes it rule 90 (left ^ right).
- SEED_INIT, 8'h01: reset seed and reset CA state. Must be nonzero.
- STRIDE, 1: CA steps between emitted words, 1..255.
- CNT_W, 16: width of the word-count request.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous reset, active-high.
- cfg_we  in  1  write cfg_rule/cfg_seed; honoured only in IDLE.
- cfg_rule  in  WIDTH  new rule vector.
- cfg_seed  in  WIDTH  new seed.
- start  in  1  begin a run; sampled only in IDLE.
- count  in  CNT_W  number of words to emit, sampled with start.
- abort  in  1  terminate the current run.
- out_data  out  WIDTH  current CA state while out_valid is high.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal completion.
- lockup  out  1  sticky flag: zero state was hit; cleared by an accepted start.
- state_q  out  WIDTH  raw CA state, for debug.

Behaviour:
- Reset (asynchronous):
  - FSM = IDLE; CA state = SEED_INIT; rule = RULE_INIT; seed = SEED_INIT.
  - out_valid, busy, done and lockup = 0; remaining = 0; step counter = 0.
- Next-state function: next[i] = l ^ r ^ (rule[i] & s[i]), with l = s[i-1] and r = s[i+1]. Null boundaries: s[-1] = s[WIDTH] = 0.
- IDLE:
  - cfg_we → rule <= cfg_rule and seed <= cfg_seed. A zero cfg_seed is stored as 8'h01.
  - start with count != 0 → remaining <= count, lockup <= 0, go to SEED.
  - start with count == 0 → done pulses the next cycle, FSM stays in IDLE.
  - If start and cfg_we arrive in the same cycle, the config write applies first and the run uses the new seed and rule.
- SEED (1 cycle): CA state <= seed; step counter <= STRIDE-1; go to STEP.
- STEP (STRIDE cycles):
  - Each cycle, CA state <= next(state).
  - If next(state) == 0, load seed instead and set lockup <= 1.
  - When the step counter reaches 0, go to EMIT.
- EMIT:
  - out_valid = 1 and out_data = state; both are held stable until out_ready.
  - On out_valid & out_ready: remaining <= remaining-1.
  - If remaining was 1, go to DONE; otherwise go to STEP and reload the step counter.
- DONE (1 cycle): done = 1, then go to IDLE. The CA state is retained, so the next run reseeds.
- abort:
  - In any non-IDLE state, the FSM is in IDLE on the next cycle; out_valid drops; no done pulse; lockup is kept.
  - In IDLE, abort is ignored.
  - abort has priority over a same-cycle out_ready handshake, which is then not counted.
- Latency: start → first out_valid = 2 + STRIDE cycles. A consumer holding ready high gets one word every STRIDE+1 cycles.
- cfg_we or start outside IDLE is ignored and has no side effects.
- RESET asserted mid-run returns everything to reset values immediately; out_valid drops asynchronously.

Decomposition:
- Package lhca_pkg:
  - FSM enum {IDLE, SEED, STEP, EMIT, DONE}.
  - Constants LHCA_RULE_DEFAULT = 8'h06 and LHCA_SEED_DEFAULT = 8'h01.
  - Function for the zero-seed substitute.
- Sub-module lhca_step: purely combinational next-state function with inputs state and rule, parameterised on WIDTH. It is reused by other LHCA blocks and checked standalone.

Test Plan:
1. Default config, STRIDE=1, start with count=3, ready held high → out_data 0x02, 0x07, 0x0B on successive valid cycles; done pulses once; busy falls the cycle after done.
2. Backpressure: same run with ready low for 5 cycles at the first word → out_valid stays high and out_data holds 0x02 throughout; the sequence resumes 0x07, 0x0B.
3. Lockup: cfg_we with rule=0xFF, seed=0xDB, then start with count=2 → first word is 0xDB; lockup=1 after that first step; lockup clears on the next start.
4. Abort: start with count=10, assert abort during the 2nd EMIT with ready high → FSM back in IDLE next cycle, out_valid=0, no done pulse, exactly 1 word counted.
5. Edge cases: start with count=0 → a single done pulse and busy never rises. cfg_we during a run → rule and seed unchanged. cfg_seed=0 in IDLE → the next run's first SEED state is 0x01.
6. Asynchronous RESET mid-STEP → outputs drop immediately; state_q=0x01 and rule=0x06 before the next clock edge.
